mem_copy_host: RTL
==================

Name: mem_copy_host

Overview:
Bus initiator for the single-port 32-bit word memory interface (req/we/be/addr/wdata out, rvalid/rdata in, read data one cycle after the request). It copies a block of N words from a source address to a destination address in the same memory. Each word is one read followed by one write. The block sits between a control agent (CPU-side register block or testbench loader) and a 1-port RAM/ROM instance.

Parameters:
LenW, 16, width of the word-count field; maximum block length is 2^LenW-1 words.

Ports:
clk_i  input  1  clock; all logic is on the rising edge
rst_ni  input  1  reset; asynchronous assertion, active-low
start_i  input  1  start a copy; sampled only while idle
src_addr_i  input  32  source byte address; bits [1:0] must be 0
dst_addr_i  input  32  destination byte address; bits [1:0] must be 0
len_i  input  LenW  number of words to copy
busy_o  output  1  high from the cycle after start is accepted until done
done_o  output  1  one-cycle pulse on completion
err_o  output  1  one-cycle pulse when a start is rejected (misaligned address)
req_o  output  1  memory request
we_o  output  1  memory write enable
be_o  output  4  byte enables; constant 4'hF whenever req_o=1, 4'h0 otherwise
addr_o  output  32  memory byte address
wdata_o  output  32  memory write data
rvalid_i  input  1  memory read/response valid
rdata_i  input  32  memory read data; valid when rvalid_i=1

Behaviour:
- Reset values: busy_o, done_o, err_o, req_o, we_o all 0; be_o, addr_o, wdata_o all 0; FSM in IDLE; internal counters 0.
- FSM states: IDLE, RD, WR, DONE.
- IDLE, start_i=1, src or dst bits [1:0] != 0:
  - err_o pulses in the next cycle; FSM stays in IDLE.
- IDLE, start_i=1, addresses aligned, len_i=0:
  - next state DONE; no memory request is issued.
- IDLE, start_i=1, addresses aligned, len_i!=0:
  - latch src, dst and len; next state RD.
- start_i while not in IDLE is ignored; no queuing.
- RD: req_o=1, we_o=0, addr_o=src pointer. Next state WR.
- WR, rvalid_i=0: req_o=0; stay in WR. This tolerates slower responders.
- WR, rvalid_i=1:
  - req_o=1, we_o=1, addr_o=dst pointer, wdata_o=rdata_i (combinational pass-through).
  - src and dst pointers each advance by 4, modulo 2^32 (wrap-around permitted).
  - remaining count decrements; next state is RD if remaining !=0 after the decrement, else DONE.
- DONE: done_o=1 for exactly one cycle; busy_o=0; next state IDLE.
- busy_o=1 in RD and WR only.
- Timing with a 1-cycle responder, start accepted at edge t:
  - first RD cycle is t+1;
  - last WR cycle is t+2N;
  - done_o pulses at t+2N+1;
  - throughput is 2 cycles per word.
- Memory outputs never show req_o=1 in IDLE or DONE.
- Overlapping regions are copied in ascending address order. When dst > src and the regions overlap, the result is undefined; this is documented and not detected.
- rvalid_i asserted in IDLE, RD or DONE is ignored.
- Reset asserted mid-copy aborts immediately. All outputs return to reset values asynchronously and no partial done is signalled.

Optional Feature:
MEM_COPY_CSUM_EN:
- Defined: adds output csum_o [31:0].
  - cleared to 0 when a start is accepted;
  - accumulates the sum modulo 2^32 of every word written;
  - stable and valid from the done_o cycle until the next accepted start;
  - reset value 0.
- Undefined: no port, no adder. Behaviour is otherwise identical.

Decomposition:
- Package mem_copy_pkg holds:
  - state enum type (IDLE, RD, WR, DONE);
  - constant for full byte enable (4'hF);
  - constant for word stride (4).
- No sub-module needed. The pointer/count datapath and FSM live in one module of about 150-250 lines.

Test Plan:
- Single word: preload mem[0x10]=0xDEADBEEF; start with src=0x10, dst=0x40, len=1 -> read req at t+1, write 0xDEADBEEF to 0x40 at t+2, done_o at t+3, busy_o high t+1..t+2.
- Burst: len=8, src=0x000, dst=0x100 with mem[i]=i*0x01010101 -> dst words match; done_o at t+17; with MEM_COPY_CSUM_EN, csum_o = 28*0x01010101 = 0x1C1C1C1C.
- Edge cases: len=0 -> done_o at t+1, req_o never high. src=0x02 -> err_o pulses at t+1, no req, busy_o stays 0.
- Stalled responder: delay rvalid_i by 3 extra cycles on word 2 -> req_o low during the stall; data still correct; done_o shifted by 3 cycles.
- Wrap and reset: src=0xFFFFFFFC, len=2 -> second read at addr 0x00000000. Separately, assert rst_ni low mid-burst -> req_o/busy_o drop immediately and no done_o; a new start afterwards completes normally.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the mem_copy_host word-copy bus initiator.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]  BE_FULL     = 4'hF;
  localparam logic [31:0] WORD_STRIDE = 32'd4;

  function automatic logic word_aligned(input logic [31:0] byte_addr);
    return byte_addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_copy_host.sv
// Copies a block of words within one single-port memory, one read then one write per word.
// Optional running checksum of written words: define MEM_COPY_CSUM_EN.
module mem_copy_host
  import mem_copy_pkg::*;
#(
  parameter int LenW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            req_o,
  output logic            we_o,
  output logic [3:0]      be_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
`ifdef MEM_COPY_CSUM_EN
  output logic [31:0]     csum_o,
`endif
  input  logic            rvalid_i,
  input  logic [31:0]     rdata_i
);

  localparam logic [LenW-1:0] LenOne = {{(LenW-1){1'b0}}, 1'b1};

  state_t          state;
  logic [31:0]     src_ptr;
  logic [31:0]     dst_ptr;
  logic [LenW-1:0] remaining;
  logic [LenW-1:0] remaining_next;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            addr_ok;
  logic            accept;
  logic            word_written;

  assign addr_ok        = word_aligned(src_addr_i) && word_aligned(dst_addr_i);
  assign accept         = (state == IDLE) && start_i && addr_ok;
  assign word_written   = (state == WR) && rvalid_i;
  assign remaining_next = remaining - LenOne;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (!addr_ok) begin
              err_q <= 1'b1;
            end else if (len_i == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              src_ptr   <= src_addr_i;
              dst_ptr   <= dst_addr_i;
              remaining <= len_i;
              busy_q    <= 1'b1;
              state     <= RD;
            end
          end
        end
        RD: state <= WR;
        WR: begin
          // Hold here until the responder returns data; pointers wrap modulo 2^32.
          if (rvalid_i) begin
            src_ptr   <= src_ptr + WORD_STRIDE;
            dst_ptr   <= dst_ptr + WORD_STRIDE;
            remaining <= remaining_next;
            if (remaining_next == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state <= RD;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  // The write is issued in the same cycle the read data arrives, so it passes straight through.
  always_comb begin
    req_o   = 1'b0;
    we_o    = 1'b0;
    be_o    = 4'h0;
    addr_o  = 32'h0;
    wdata_o = 32'h0;
    case (state)
      RD: begin
        req_o  = 1'b1;
        be_o   = BE_FULL;
        addr_o = src_ptr;
      end
      WR: begin
        if (rvalid_i) begin
          req_o   = 1'b1;
          we_o    = 1'b1;
          be_o    = BE_FULL;
          addr_o  = dst_ptr;
          wdata_o = rdata_i;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_COPY_CSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (word_written) begin
      csum <= csum + rdata_i;
    end
  end

  assign csum_o = csum;
`else
  // Without the checksum option there is no accumulator and no extra port.
`endif

endmodule
